// File: rtl/toggle_ctrl_pkg.sv
// Shared definitions for the toggle burst controller: FSM encoding, CLEAR timing
// and the expectation update helper.
package toggle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned CLEAR_CNT_W = 4;
  // Number of cycles the datapath is held in reset before shifting starts.
  localparam logic [CLEAR_CNT_W-1:0] CLEAR_CYCLES = 4'd1;

  // exp[0] tracks parity of ones, exp[1] tracks parity of zeros.
  function automatic logic [1:0] next_expect(input logic [1:0] cur, input logic din);
    return {cur[1] ^ ~din, cur[0] ^ din};
  endfunction

endpackage

// File: rtl/toggle_expect.sv
// Expectation tracker: follows the driven bit stream and checks the datapath
// state against it when the burst completes.
module toggle_expect
  import toggle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       shift_bit,
  input  logic       cap,
  input  logic [1:0] dp_out,
  output logic [1:0] result,
  output logic       err
);

  logic [1:0] exp_r;
  logic [1:0] result_r;
  logic       err_r;

  // Running parity of ones/zeros for the active burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= 2'b00;
    end else if (clr) begin
      exp_r <= 2'b00;
    end else if (shift_en) begin
      exp_r <= next_expect(exp_r, shift_bit);
    end else begin
      exp_r <= exp_r;
    end
  end

  // Snapshot and compare; held until the next completed burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 2'b00;
      err_r    <= 1'b0;
    end else if (cap) begin
      result_r <= dp_out;
      err_r    <= (dp_out != exp_r);
    end else begin
      result_r <= result_r;
      err_r    <= err_r;
    end
  end

  assign result = result_r;
  assign err    = err_r;

endmodule

// File: rtl/toggle_burst_ctrl.sv
// Burst controller: clears the toggle datapath, shifts a pattern into it LSB
// first, then snapshots the datapath state and flags a mismatch.
module toggle_burst_ctrl
  import toggle_ctrl_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PAT_W-1:0] req_pattern,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
  output logic             dp_rst,
  output logic             dp_in,
  input  logic [1:0]       dp_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic             err
);

  state_t                 state_r;
  logic [PAT_W-1:0]       pattern_r;
  logic [LEN_W-1:0]       len_r;
  logic [LEN_W-1:0]       idx_r;
  logic [CLEAR_CNT_W-1:0] clr_cnt_r;
  logic                   dp_rst_r;

  logic                   accept_s;
  logic                   shift_en_s;
  logic                   cap_s;
  logic                   dp_in_s;

  // Handshake and tracker strobes decoded from the current state.
  always_comb begin
    accept_s   = 1'b0;
    shift_en_s = 1'b0;
    cap_s      = 1'b0;
    dp_in_s    = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = req_valid;
    end else if (state_r == ST_SHIFT) begin
      shift_en_s = ~abort;
      dp_in_s    = pattern_r[idx_r];
    end else if (state_r == ST_WAIT) begin
      cap_s = ~abort;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Main controller FSM; dp_rst is high in CLEAR and for one cycle after abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pattern_r <= '0;
      len_r     <= '0;
      idx_r     <= '0;
      clr_cnt_r <= '0;
      dp_rst_r  <= 1'b1;
    end else begin
      dp_rst_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            pattern_r <= req_pattern;
            len_r     <= req_len;
            idx_r     <= '0;
            clr_cnt_r <= '0;
            dp_rst_r  <= 1'b1;
            state_r   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            dp_rst_r <= 1'b1;
            state_r  <= ST_IDLE;
          end else if (clr_cnt_r == CLEAR_CYCLES - 4'd1) begin
            state_r <= ST_SHIFT;
          end else begin
            clr_cnt_r <= clr_cnt_r + 4'd1;
            dp_rst_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            dp_rst_r <= 1'b1;
            state_r  <= ST_IDLE;
          end else if (idx_r == len_r) begin
            state_r <= ST_WAIT;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            dp_rst_r <= 1'b1;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  toggle_expect u_expect (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept_s),
    .shift_en (shift_en_s),
    .shift_bit(dp_in_s),
    .cap      (cap_s),
    .dp_out   (dp_out),
    .result   (result),
    .err      (err)
  );

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
  assign dp_rst    = dp_rst_r;
  assign dp_in     = dp_in_s;

endmodule
